gate_array_pipe: RTL and testbench

// - Parametrised, pipelined successor to the team's 2-input combinational gate: applies a selectable bitwise

---
 rtl/gate_array_pkg.sv | 51 +++++
 rtl/gate_array_reduce.sv | 28 ++
 rtl/gate_array_pipe.sv | 173 +++++++++++++++++
 tb/tb_gate_array_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_array_pkg.sv
// gate_array_pkg: shared definitions for the gate_array_pipe logic-combine stage.
//   - OP_* : 3-bit operation encoding carried on in_op
//   - base_fn_t : reduction primitive applied across operands / beats
//   - state_t : burst FSM states
//   - op_base / op_inv / op_rsvd : decode of an op into primitive, output
//     inversion and reserved flag
package gate_array_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        BF_AND,
        BF_OR,
        BF_XOR,
        BF_PASS
    } base_fn_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_t;

    // Inverting ops share the primitive of their plain counterpart; the
    // inversion is applied only once, when a result is emitted.
    function automatic base_fn_t op_base(input logic [2:0] op);
        base_fn_t fn;
        case (op)
            OP_AND, OP_NAND: fn = BF_AND;
            OP_OR,  OP_NOR:  fn = BF_OR;
            OP_XOR, OP_XNOR: fn = BF_XOR;
            default:         fn = BF_PASS;
        endcase
        return fn;
    endfunction

    function automatic logic op_inv(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic op_rsvd(input logic [2:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/gate_array_reduce.sv
// gate_array_reduce: combinational bitwise reduction of NIN packed operands.
//   data   : NIN operands, operand k at [k*WIDTH +: WIDTH]
//   fn     : primitive (AND/OR/XOR, or PASS which returns operand 0)
//   result : WIDTH-bit reduced value
module gate_array_reduce
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2
) (
    input  logic [NIN*WIDTH-1:0] data,
    input  base_fn_t             fn,
    output logic [WIDTH-1:0]     result
);

    always_comb begin
        result = data[0 +: WIDTH];
        for (int unsigned k = 1; k < NIN; k++) begin
            case (fn)
                BF_AND:  result = result & data[k*WIDTH +: WIDTH];
                BF_OR:   result = result | data[k*WIDTH +: WIDTH];
                BF_XOR:  result = result ^ data[k*WIDTH +: WIDTH];
                default: result = result;
            endcase
        end
    end

endmodule

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: two-stage valid/ready logic-combine stage.
//   in_*  : producer stream (in_data = NIN packed operands, in_op selects the
//           function, in_acc/in_last frame accumulate bursts)
//   out_* : consumer stream (out_data result, out_all/out_any reductions of
//           out_data, out_err for reserved op, out_beats = beats folded)
// S1 holds the per-beat raw reduction; S2 is the output register plus the
// IDLE/ACC burst FSM that folds burst beats into one result.
module gate_array_pipe
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [2:0]           in_op,
    input  logic                 in_acc,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_all,
    output logic                 out_any,
    output logic                 out_err,
    output logic [CNTW-1:0]      out_beats
);

    // ---------------- S1 ----------------
    logic             rdy_en;      // holds in_ready low until the first edge after reset
    logic             s1_valid;
    logic [WIDTH-1:0] s1_raw;
    logic [2:0]       s1_op;
    logic             s1_acc;
    logic             s1_last;

    // Burst framing is tracked at the input so that non-first beats are
    // reduced with the burst's op rather than their own in_op.
    logic             in_burst;
    logic [2:0]       burst_op;

    logic [2:0]       eff_op;
    logic             eff_acc;
    logic             eff_last;
    logic [WIDTH-1:0] in_raw;
    logic             accept;
    logic             s1_take;

    assign eff_op   = in_burst ? burst_op : in_op;
    assign eff_acc  = in_burst | in_acc;
    assign eff_last = eff_acc & in_last;
    assign accept   = in_valid & in_ready;

    gate_array_reduce #(.WIDTH(WIDTH), .NIN(NIN)) u_reduce (
        .data   (in_data),
        .fn     (op_base(eff_op)),
        .result (in_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_op    <= OP_AND;
            s1_acc   <= 1'b0;
            s1_last  <= 1'b0;
            in_burst <= 1'b0;
            burst_op <= OP_AND;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                s1_valid <= 1'b1;
                s1_raw   <= in_raw;
                s1_op    <= eff_op;
                s1_acc   <= eff_acc;
                s1_last  <= eff_last;
                if (eff_acc && !in_last) begin
                    in_burst <= 1'b1;
                    if (!in_burst)
                        burst_op <= in_op;
                end else begin
                    in_burst <= 1'b0;
                end
            end else if (s1_take) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ---------------- S2 ----------------
    state_t           state;
    logic [WIDTH-1:0] acc_data;
    logic [CNTW-1:0]  acc_cnt;
    logic [2:0]       acc_op;
    logic             acc_err;

    logic [WIDTH-1:0] fold_data;
    logic [CNTW-1:0]  cnt_inc;
    logic             s1_emits;
    logic             s2_free;

    // Operand 0 is the new beat so PASS folds to the latest op0.
    gate_array_reduce #(.WIDTH(WIDTH), .NIN(2)) u_fold (
        .data   ({acc_data, s1_raw}),
        .fn     (op_base(acc_op)),
        .result (fold_data)
    );

    assign cnt_inc  = (acc_cnt == '1) ? acc_cnt : acc_cnt + CNTW'(1);
    assign s1_emits = (state == ST_IDLE) ? (!s1_acc || s1_last) : s1_last;
    assign s2_free  = !out_valid || out_ready;
    // Beats absorbed into the accumulator never need the output register.
    assign s1_take  = s1_valid && (s2_free || !s1_emits);
    assign in_ready = rdy_en && (!s1_valid || s1_take);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc_data  <= '0;
            acc_cnt   <= '0;
            acc_op    <= OP_AND;
            acc_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_beats <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (s1_take) begin
                case (state)
                    ST_IDLE: begin
                        if (s1_emits) begin
                            out_valid <= 1'b1;
                            out_data  <= op_rsvd(s1_op) ? '0 :
                                         (op_inv(s1_op) ? ~s1_raw : s1_raw);
                            out_err   <= op_rsvd(s1_op);
                            out_beats <= CNTW'(1);
                        end else begin
                            acc_data <= s1_raw;
                            acc_op   <= s1_op;
                            acc_cnt  <= CNTW'(1);
                            acc_err  <= op_rsvd(s1_op);
                            state    <= ST_ACC;
                        end
                    end
                    ST_ACC: begin
                        if (s1_last) begin
                            out_valid <= 1'b1;
                            out_data  <= acc_err ? '0 :
                                         (op_inv(acc_op) ? ~fold_data : fold_data);
                            out_err   <= acc_err;
                            out_beats <= cnt_inc;
                            state     <= ST_IDLE;
                        end else begin
                            acc_data <= fold_data;
                            acc_cnt  <= cnt_inc;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_all = &out_data;
    assign out_any = |out_data;

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb_gate_array_pipe: directed self-checking bench for gate_array_pipe
// (WIDTH=8, NIN=2, CNTW=8).
module tb_gate_array_pipe;
    import gate_array_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_op;
    logic        in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_all;
    logic        out_any;
    logic        out_err;
    logic [7:0]  out_beats;

    int checks = 0;
    int errors = 0;

    gate_array_pipe #(.WIDTH(8), .NIN(2), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_all   (out_all),
        .out_any   (out_any),
        .out_err   (out_err),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [2:0] op,
                        input logic acc, input logic last);
        int n;
        n = 0;
        in_data  = d;
        in_op    = op;
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the next consumed result; n = negedges waited.
    task automatic wait_out(output logic [7:0] d, output logic e, output logic [7:0] b,
                            output logic al, output logic an, output int n);
        n  = 0;
        d  = '0;
        e  = 1'b0;
        b  = '0;
        al = 1'b0;
        an = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (out_valid && out_ready) begin
                d  = out_data;
                e  = out_err;
                b  = out_beats;
                al = out_all;
                an = out_any;
                break;
            end
            if (n >= 400) begin
                checks++;
                errors++;
                $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if ({out_data, out_beats, out_err, out_all, out_any} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h beats=%0d err=%b all=%b any=%b required all 0",
                     out_data, out_beats, out_err, out_all, out_any);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b required 1", in_ready); end
    endtask

    task automatic test_single_and();
        logic [7:0] d, b;
        logic e, al, an;
        int n;
        send({8'hF0, 8'h3C}, OP_AND, 1'b0, 1'b0);
        wait_out(d, e, b, al, an, n);
        checks++;
        if (d !== 8'h30) begin errors++; $display("FAIL single_and_data: got %h required 30", d); end
        checks++;
        if (b !== 8'd1 || e !== 1'b0) begin errors++; $display("FAIL single_and_meta: beats=%0d err=%b required 1/0", b, e); end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL single_and_latency: got %0d cycles required 2", n); end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_d[8] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5, 8'h50, 8'h5A, 8'h0F, 8'h00};
        logic [7:0] d, b;
        logic e, al, an;
        int n;
        for (int i = 0; i < 8; i++) begin
            send({8'hAA, 8'h0F}, 3'(i), 1'b0, 1'b1);
            wait_out(d, e, b, al, an, n);
            checks++;
            if (d !== exp_d[i] || e !== (i == 7) || b !== 8'd1) begin
                errors++;
                $display("FAIL op_%0d: data=%h err=%b beats=%0d required %h/%b/1",
                         i, d, e, b, exp_d[i], (i == 7));
            end
            checks++;
            if (an !== (exp_d[i] != 8'h00) || al !== 1'b0) begin
                errors++;
                $display("FAIL op_%0d_flags: any=%b all=%b required %b/0", i, an, al, (exp_d[i] != 8'h00));
            end
        end
        send({8'hF0, 8'h0F}, OP_OR, 1'b0, 1'b0);
        wait_out(d, e, b, al, an, n);
        checks++;
        if (d !== 8'hFF || al !== 1'b1 || an !== 1'b1) begin
            errors++;
            $display("FAIL or_all: data=%h all=%b any=%b required FF/1/1", d, al, an);
        end
    endtask

    task automatic test_burst_and();
        logic [7:0] d, b;
        logic e, al, an;
        int n;
        send({8'hFF, 8'hF3}, OP_AND, 1'b1, 1'b0);
        // op/acc of non-first beats must be ignored
        send({8'h7F, 8'hFF}, OP_OR, 1'b0, 1'b0);
        send({8'hFE, 8'hFF}, OP_XOR, 1'b1, 1'b1);
        wait_out(d, e, b, al, an, n);
        checks++;
        if (d !== 8'h72 || b !== 8'd3 || e !== 1'b0) begin
            errors++;
            $display("FAIL burst_and: data=%h beats=%0d err=%b required 72/3/0", d, b, e);
        end
        checks++;
        if (an !== 1'b1 || al !== 1'b0) begin errors++; $display("FAIL burst_and_flags: any=%b all=%b required 1/0", an, al); end
    endtask

    task automatic test_burst_rsvd();
        logic [7:0] d, b;
        logic e, al, an;
        int n;
        send({8'h12, 8'h34}, OP_RSVD, 1'b1, 1'b0);
        send({8'hFF, 8'hFF}, OP_AND, 1'b1, 1'b1);
        wait_out(d, e, b, al, an, n);
        checks++;
        if (d !== 8'h00 || e !== 1'b1 || b !== 8'd2) begin
            errors++;
            $display("FAIL burst_rsvd: data=%h err=%b beats=%0d required 00/1/2", d, e, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vec[4] = '{16'hF03C, 16'h0102, 16'hFF0F, 16'h0000};
        logic [2:0]  ops[4] = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
        logic [7:0]  exp_d[4] = '{8'h30, 8'h03, 8'hF0, 8'hFF};
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(vec[i], ops[i], 1'b0, 1'b0);
            end
            begin
                logic [7:0] d, b;
                logic e, al, an;
                int n;
                repeat (2) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== 8'h30) begin
                        errors++;
                        $display("FAIL stall_hold_%0d: valid=%b data=%h required 1/30", k, out_valid, out_data);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    wait_out(d, e, b, al, an, n);
                    checks++;
                    if (d !== exp_d[i] || b !== 8'd1) begin
                        errors++;
                        $display("FAIL drain_%0d: data=%h beats=%0d required %h/1", i, d, b, exp_d[i]);
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_extra: out_valid=%b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] d, b;
        logic e, al, an;
        int n;
        send({8'h01, 8'h02}, OP_NOR, 1'b1, 1'b0);
        send({8'h04, 8'h08}, OP_NOR, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL open_burst_output: out_valid=%b required 0", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send({8'h01, 8'h02}, OP_OR, 1'b0, 1'b0);
        wait_out(d, e, b, al, an, n);
        checks++;
        if (d !== 8'h03 || b !== 8'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_or: data=%h beats=%0d err=%b required 03/1/0", d, b, e);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d, b;
        logic e, al, an;
        logic [7:0] exp_x;
        int n;
        exp_x = 8'h00;
        for (int i = 0; i < 300; i++) begin
            send({8'(i * 7), 8'(i)}, OP_XOR, 1'b1, (i == 299));
            exp_x = exp_x ^ 8'(i * 7) ^ 8'(i);
        end
        wait_out(d, e, b, al, an, n);
        checks++;
        if (b !== 8'd255) begin errors++; $display("FAIL sat_beats: got %0d required 255", b); end
        checks++;
        if (d !== exp_x || e !== 1'b0) begin errors++; $display("FAIL sat_data: data=%h err=%b required %h/0", d, e, exp_x); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single_and();
        test_all_ops();
        test_burst_and();
        test_burst_rsvd();
        test_back_to_back();
        test_reset_mid_burst();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
